// File: rtl/imm_alu_sequencer.sv
// Moore control sequencer for immediate ALU instructions (addi/andi/ori):
// fetch with a variable-latency memory handshake, decode, execute, writeback.
module imm_alu_sequencer #(
    parameter int                OPC_W       = 5,
    parameter int                CTRL_W      = 5,
    parameter logic [OPC_W-1:0]  OPC_ADDI    = 5'b01011,
    parameter logic [OPC_W-1:0]  OPC_ANDI    = 5'b01100,
    parameter logic [OPC_W-1:0]  OPC_ORI     = 5'b01101,
    parameter logic [CTRL_W-1:0] ALU_ADD     = 5'b00011,
    parameter logic [CTRL_W-1:0] ALU_AND     = 5'b01000,
    parameter logic [CTRL_W-1:0] ALU_OR      = 5'b01001,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Start,
    input  logic              Mem_Ready,
    input  logic [OPC_W-1:0]  IR_Opcode,
    output logic [CTRL_W-1:0] CONTROL,
    output logic              IncPC,
    output logic              Read,
    output logic              PC_Out,
    output logic              MDR_Out,
    output logic              ZLO_Out,
    output logic              C_Out,
    output logic              MDR_In,
    output logic              MAR_In,
    output logic              IR_In,
    output logic              Y_In,
    output logic              ZLO_In,
    output logic              G_RA,
    output logic              G_RB,
    output logic              BA_Out,
    output logic              R_In,
    output logic              Busy,
    output logic              Done,
    output logic              Illegal,
    output logic              Timeout
);

    // state | meaning
    // IDLE  | waiting for Start
    // T0    | PC -> MAR, PC increment
    // T1W   | memory read outstanding, counting wait cycles
    // T1L   | memory data -> MDR
    // T2    | MDR -> IR
    // T3    | Rb -> Y, opcode decode
    // T4    | ALU operation -> Z
    // T5    | Z -> Ra, Done
    // FAULT | Illegal or Timeout pulse
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1W, S_T1L, S_T2, S_T3, S_T4, S_T5, S_FAULT
    } state_e;

    localparam int CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int WAIT_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] WAIT_LAST = WAIT_LAST_I[CNT_W-1:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CTRL_W-1:0] alu_code_q, alu_code_d;
    logic              cause_to_q, cause_to_d;
    logic              wait_last;

    // Fault fires on the cycle the incremented count would reach MEM_TIMEOUT,
    // so exactly MEM_TIMEOUT cycles are spent in T1W.
    assign wait_last = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            alu_code_q <= '0;
            cause_to_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            alu_code_q <= alu_code_d;
            cause_to_q <= cause_to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        alu_code_d = alu_code_q;
        cause_to_d = cause_to_q;
        case (state_q)
            S_IDLE: if (Start) state_d = S_T0;
            S_T0: begin
                wait_cnt_d = '0;
                state_d    = S_T1W;
            end
            S_T1W: begin
                if (Mem_Ready) begin
                    state_d = S_T1L;
                end else if (wait_last) begin
                    state_d    = S_FAULT;
                    cause_to_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_T1L: state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3: begin
                state_d = S_T4;
                if (IR_Opcode == OPC_ADDI) begin
                    alu_code_d = ALU_ADD;
                end else if (IR_Opcode == OPC_ANDI) begin
                    alu_code_d = ALU_AND;
                end else if (IR_Opcode == OPC_ORI) begin
                    alu_code_d = ALU_OR;
                end else begin
                    alu_code_d = '0;
                    cause_to_d = 1'b0;
                    state_d    = S_FAULT;
                end
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CONTROL = '0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        C_Out   = 1'b0;
        MDR_In  = 1'b0;
        MAR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        G_RA    = 1'b0;
        G_RB    = 1'b0;
        BA_Out  = 1'b0;
        R_In    = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        Timeout = 1'b0;
        Busy    = (state_q != S_IDLE);
        case (state_q)
            S_T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
            end
            S_T1W: Read = 1'b1;
            S_T1L: begin
                Read   = 1'b1;
                MDR_In = 1'b1;
            end
            S_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            S_T3: begin
                G_RB   = 1'b1;
                BA_Out = 1'b1;
                Y_In   = 1'b1;
            end
            S_T4: begin
                C_Out   = 1'b1;
                ZLO_In  = 1'b1;
                CONTROL = alu_code_q;
            end
            S_T5: begin
                ZLO_Out = 1'b1;
                G_RA    = 1'b1;
                R_In    = 1'b1;
                Done    = 1'b1;
            end
            S_FAULT: begin
                Illegal = ~cause_to_q;
                Timeout = cause_to_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Bench for imm_alu_sequencer: table vectors, randomized instructions against a
// cycle-trace reference model, and hand-written Clear / Start corner cases.
module tb_imm_alu_sequencer;

    localparam int TMO = 15;

    logic       Clock = 1'b0;
    logic       Clear, Start, Mem_Ready;
    logic [4:0] IR_Opcode;
    logic [4:0] CONTROL;
    logic IncPC, Read, PC_Out, MDR_Out, ZLO_Out, C_Out, MDR_In, MAR_In, IR_In;
    logic Y_In, ZLO_In, G_RA, G_RB, BA_Out, R_In, Busy, Done, Illegal, Timeout;

    int vectors = 0;
    int miscompares = 0;

    imm_alu_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Mem_Ready(Mem_Ready),
        .IR_Opcode(IR_Opcode), .CONTROL(CONTROL), .IncPC(IncPC), .Read(Read),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .C_Out(C_Out),
        .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
        .ZLO_In(ZLO_In), .G_RA(G_RA), .G_RB(G_RB), .BA_Out(BA_Out), .R_In(R_In),
        .Busy(Busy), .Done(Done), .Illegal(Illegal), .Timeout(Timeout)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [4:0] control;
        logic incpc, read, pc_out, mdr_out, zlo_out, c_out, mdr_in, mar_in, ir_in;
        logic y_in, zlo_in, g_ra, g_rb, ba_out, r_in, busy, done, illegal, timeout;
    } out_t;

    typedef enum {P_IDLE, P_T0, P_T1W, P_T1L, P_T2, P_T3, P_T4, P_T5, P_FILL, P_FTMO} phase_e;

    function automatic out_t observe();
        out_t o;
        o = '{CONTROL, IncPC, Read, PC_Out, MDR_Out, ZLO_Out, C_Out, MDR_In, MAR_In,
              IR_In, Y_In, ZLO_In, G_RA, G_RB, BA_Out, R_In, Busy, Done, Illegal, Timeout};
        return o;
    endfunction

    // Output bundle each phase of the instruction is required to show.
    function automatic out_t expect_out(phase_e p, logic [4:0] ctrl);
        out_t o = '0;
        case (p)
            P_T0:   begin o.pc_out = 1; o.mar_in = 1; o.incpc = 1; end
            P_T1W:  o.read = 1;
            P_T1L:  begin o.read = 1; o.mdr_in = 1; end
            P_T2:   begin o.mdr_out = 1; o.ir_in = 1; end
            P_T3:   begin o.g_rb = 1; o.ba_out = 1; o.y_in = 1; end
            P_T4:   begin o.c_out = 1; o.zlo_in = 1; o.control = ctrl; end
            P_T5:   begin o.zlo_out = 1; o.g_ra = 1; o.r_in = 1; o.done = 1; end
            P_FILL: o.illegal = 1;
            P_FTMO: o.timeout = 1;
            default: ;
        endcase
        o.busy = (p != P_IDLE);
        return o;
    endfunction

    function automatic logic [4:0] alu_of(logic [4:0] op, output bit legal);
        legal = 1;
        if (op == 5'b01011) return 5'b00011;
        if (op == 5'b01100) return 5'b01000;
        if (op == 5'b01101) return 5'b01001;
        legal = 0;
        return 5'b00000;
    endfunction

    phase_e     exp_q[$];
    logic [4:0] exp_ctrl;

    // d = number of not-ready cycles before Mem_Ready rises while the read waits.
    task automatic build_trace(input logic [4:0] op, input int d);
        bit legal;
        int nw;
        exp_q.delete();
        exp_ctrl = alu_of(op, legal);
        exp_q.push_back(P_T0);
        nw = (d >= TMO) ? TMO : d + 1;
        repeat (nw) exp_q.push_back(P_T1W);
        if (d >= TMO) begin
            exp_q.push_back(P_FTMO);
            return;
        end
        exp_q.push_back(P_T1L);
        exp_q.push_back(P_T2);
        exp_q.push_back(P_T3);
        if (legal) begin
            exp_q.push_back(P_T4);
            exp_q.push_back(P_T5);
        end else begin
            exp_q.push_back(P_FILL);
        end
    endtask

    task automatic cmp_out(input string name, input int k, input out_t a, input out_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h want %h", name, k, a, e);
        end
    endtask

    task automatic cmp_int(input string name, input int a, input int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, a, e);
        end
    endtask

    // Called at #1 after an edge with the DUT idle; returns at #1 after an edge.
    task automatic run_instr(input string name, input logic [4:0] op, input int d,
                             input int pulse_k, input bit hold,
                             output int ev_k, output int ev_kind, output int ctrl_seen,
                             output int reads, output int incs, output int rins);
        int len;
        out_t o;
        build_trace(op, d);
        len = exp_q.size();
        exp_q.push_back(P_IDLE);
        if (hold) begin
            for (int i = 0; i < len; i++) exp_q.push_back(exp_q[i]);
            exp_q.push_back(P_IDLE);
        end
        ev_k = 0; ev_kind = -1; ctrl_seen = 0; reads = 0; incs = 0; rins = 0;
        IR_Opcode = op;
        Mem_Ready = 1'b0;
        Start     = 1'b1;
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(posedge Clock);
            #1;
            Start     = (hold && k <= len + 1) || (k == pulse_k);
            Mem_Ready = (k >= 2 + d);
            o = observe();
            cmp_out(name, k, o, expect_out(exp_q[k-1], exp_ctrl));
            if (ev_k == 0 && (o.done || o.illegal || o.timeout)) begin
                ev_k    = k;
                ev_kind = o.done ? 0 : (o.illegal ? 1 : 2);
            end
            if (o.control != 5'b0) ctrl_seen = int'(o.control);
            reads += int'(o.read);
            incs  += int'(o.incpc);
            rins  += int'(o.r_in);
        end
        Start     = 1'b0;
        Mem_Ready = 1'b0;
    endtask

    task automatic clear_during(input string name, input logic [4:0] op, input int d,
                                input int kclr);
        build_trace(op, d);
        IR_Opcode = op;
        Start     = 1'b1;
        for (int k = 1; k <= kclr; k++) begin
            @(posedge Clock);
            #1;
            Start     = 1'b1;
            Mem_Ready = (k >= 2 + d);
            cmp_out(name, k, observe(), expect_out(exp_q[k-1], exp_ctrl));
        end
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        Start = 1'b0;
        cmp_out({name, "_cleared"}, kclr + 1, observe(), expect_out(P_IDLE, 5'b0));
        @(posedge Clock);
        #1;
        cmp_out({name, "_idle"}, kclr + 2, observe(), expect_out(P_IDLE, 5'b0));
        Mem_Ready = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [4:0] op;
        int         d;
        int         pulse_k;
        int         ev_k;
        int         ev_kind;
        int         ctrl;
        int         reads;
        int         rins;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ek, ekind, cs, rd, ic, ri;
        tbl[0] = '{"andi_ready",   5'b01100, 0,  0, 7,  0, 8, 2,  1};
        tbl[1] = '{"addi_wait3",   5'b01011, 3,  0, 10, 0, 3, 5,  1};
        tbl[2] = '{"ori_wait3",    5'b01101, 3,  0, 10, 0, 9, 5,  1};
        tbl[3] = '{"illegal_0003", 5'b00011, 0,  0, 6,  1, 0, 2,  0};
        tbl[4] = '{"timeout",      5'b01100, 99, 0, 17, 2, 0, 15, 0};
        tbl[5] = '{"ready_last",   5'b01100, 14, 0, 21, 0, 8, 16, 1};
        tbl[6] = '{"start_in_t2",  5'b01101, 0,  4, 7,  0, 9, 2,  1};
        tbl[7] = '{"illegal_1f",   5'b11111, 2,  0, 8,  1, 0, 4,  0};

        Clear = 1'b1;
        Start = 1'b1;
        Mem_Ready = 1'b0;
        IR_Opcode = 5'b0;
        repeat (2) @(posedge Clock);
        #1;
        cmp_out("reset_clear_start", 0, observe(), '0);
        Clear = 1'b0;
        Start = 1'b0;
        @(posedge Clock);
        #1;
        cmp_out("reset_idle", 0, observe(), '0);

        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].name, tbl[i].op, tbl[i].d, tbl[i].pulse_k, 1'b0,
                      ek, ekind, cs, rd, ic, ri);
            cmp_int({tbl[i].name, "_event_cycle"}, ek, tbl[i].ev_k);
            cmp_int({tbl[i].name, "_event_kind"}, ekind, tbl[i].ev_kind);
            cmp_int({tbl[i].name, "_control"}, cs, tbl[i].ctrl);
            cmp_int({tbl[i].name, "_read_cycles"}, rd, tbl[i].reads);
            cmp_int({tbl[i].name, "_incpc_count"}, ic, 1);
            cmp_int({tbl[i].name, "_rin_count"}, ri, tbl[i].rins);
        end

        clear_during("clear_in_t4", 5'b01100, 0, 6);
        clear_during("clear_in_t1w", 5'b01011, 6, 5);
        run_instr("after_clear", 5'b01011, 14, 0, 1'b0, ek, ekind, cs, rd, ic, ri);
        cmp_int("after_clear_read_cycles", rd, 16);

        run_instr("start_held", 5'b01100, 0, 0, 1'b1, ek, ekind, cs, rd, ic, ri);
        cmp_int("start_held_incpc_count", ic, 2);
        cmp_int("start_held_rin_count", ri, 2);

        for (int n = 0; n < 24; n++) begin
            logic [4:0] op;
            int d, pk, sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: op = 5'b01011;
                1: op = 5'b01100;
                2: op = 5'b01101;
                default: op = 5'($urandom_range(0, 31));
            endcase
            d  = int'($urandom_range(0, 18));
            pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : 0;
            run_instr("random", op, d, pk, 1'b0, ek, ekind, cs, rd, ic, ri);
            cmp_int("random_incpc_count", ic, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
